// File: rtl/lcd_controller.sv
// rtl/lcd_controller.sv - HD44780 write-only controller with power-on init and four-phase host handshake
module lcd_controller #(
    parameter int SETUP_CYCLES      = 4,
    parameter int PULSE_CYCLES      = 13,
    parameter int HOLD_CYCLES       = 2,
    parameter int SHORT_WAIT_CYCLES = 2000,
    parameter int LONG_WAIT_CYCLES  = 80000,
    parameter int POWERON_CYCLES    = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ctrl_data,
    input  logic       ctrl_data_is_cmd,
    input  logic       ctrl_data_req,
    output logic       ctrl_data_ack,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       init_done
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYCLES = max2(max2(max2(SETUP_CYCLES, PULSE_CYCLES), max2(HOLD_CYCLES, SHORT_WAIT_CYCLES)),
                                     max2(LONG_WAIT_CYCLES, POWERON_CYCLES));
    localparam int CW = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    // Counter is loaded with N-1 so a phase of N cycles ends on the edge that sees zero.
    localparam logic [CW-1:0] SETUP_LOAD   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SHORT_LOAD   = CW'(SHORT_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LOAD    = CW'(LONG_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] POWERON_LOAD = CW'(POWERON_CYCLES - 1);

    typedef enum logic [2:0] {
        POWER_WAIT,
        SETUP,
        PULSE,
        HOLD,
        EXEC_WAIT,
        ACK,
        IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          ack_q, ack_d;
    logic          done_q, done_d;
    logic [1:0]    idx_q, idx_d;
    logic          cnt_zero;
    logic          long_wait;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    assign cnt_zero  = (cnt_q == '0);
    // Clear (0x01) and return-home (0x02/0x03) need the long execution delay.
    assign long_wait = !rs_q && (data_q[7:2] == 6'b0) && (data_q[1:0] != 2'b0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= POWER_WAIT;
            cnt_q   <= POWERON_LOAD;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        ack_d   = ack_q;
        done_d  = done_q;
        idx_d   = idx_q;

        case (state_q)
            POWER_WAIT: begin
                if (cnt_zero) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LOAD;
                    rs_d    = 1'b0;
                    data_d  = init_byte(idx_q);
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                    e_d     = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    e_d     = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d = EXEC_WAIT;
                    cnt_d   = long_wait ? LONG_LOAD : SHORT_LOAD;
                end
            end
            EXEC_WAIT: begin
                if (cnt_zero) begin
                    if (done_q) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                    end else if (idx_q == 2'd3) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LOAD;
                        idx_d   = idx_q + 2'd1;
                        rs_d    = 1'b0;
                        data_d  = init_byte(idx_q + 2'd1);
                    end
                end
            end
            ACK: begin
                if (!ctrl_data_req) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
            IDLE: begin
                if (ctrl_data_req && !ack_q) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LOAD;
                    rs_d    = ~ctrl_data_is_cmd;
                    data_d  = ctrl_data;
                end
            end
            default: begin
                state_d = POWER_WAIT;
            end
        endcase
    end

    assign ctrl_data_ack = ack_q;
    assign lcd_e         = e_q;
    assign lcd_rs        = rs_q;
    assign lcd_rw        = 1'b0;
    assign lcd_data      = data_q;
    assign init_done     = done_q;

endmodule

// File: doc/lcd_controller.md
# lcd_controller

Far-end consumer of the LCD request/acknowledge channel: accepts byte transfers (data or command) from the LCD bus interface and drives an HD44780-compatible character display over its 8-bit parallel write-only pin interface. After reset it runs a fixed power-on initialisation sequence, then serves host transfers one at a time. Each transfer uses a four-phase handshake, and every write is followed by the display's required execution delay.

## Interface
- SETUP_CYCLES, 4: clocks that rs/data are stable before lcd_e rises (≥40 ns at 50 MHz).
- PULSE_CYCLES, 13: clocks lcd_e is held high (≥230 ns).
- HOLD_CYCLES, 2: clocks rs/data are held after lcd_e falls.
- SHORT_WAIT_CYCLES, 2000: execution delay after an ordinary write (40 µs).
- LONG_WAIT_CYCLES, 80000: execution delay after clear/home (1.6 ms).
- POWERON_CYCLES, 1000000: idle time after reset before the first init write (20 ms).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctrl_data  in  8  byte to write; sampled only when a transfer is accepted.
- ctrl_data_is_cmd  in  1  1 = command (rs=0), 0 = data (rs=1); sampled with ctrl_data.
- ctrl_data_req  in  1  transfer request, level, four-phase.
- ctrl_data_ack  out  1  transfer complete; held until req falls.
- lcd_e  out  1  display enable strobe.
- lcd_rs  out  1  display register select.
- lcd_rw  out  1  constant 0 (write-only).
- lcd_data  out  8  display data bus.
- init_done  out  1  high once the init sequence has completed; stays high until reset.

## Operation
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, ctrl_data_ack=0, init_done=0, state=POWER_WAIT, init index=0.
- States: POWER_WAIT, SETUP, PULSE, HOLD, EXEC_WAIT, ACK, IDLE.
- POWER_WAIT: count POWERON_CYCLES, then load init byte 0 and enter SETUP.
- Init sequence: all bytes are commands (rs=0), in order 0x38, 0x0C, 0x01, 0x06.
  - After each init write's EXEC_WAIT, advance to the next byte (SETUP).
  - After the 4th byte, set init_done=1 and enter IDLE.
  - Init writes never assert ctrl_data_ack.
- IDLE: when ctrl_data_req=1 and ctrl_data_ack=0:
  - latch lcd_data=ctrl_data and lcd_rs=~ctrl_data_is_cmd;
  - enter SETUP.
- Transfer: SETUP (lcd_e=0) → PULSE (lcd_e=1) → HOLD (lcd_e=0) → EXEC_WAIT.
  - lcd_rs and lcd_data stay constant from the latch edge through the end of EXEC_WAIT.
- Wait selection:
  - LONG_WAIT_CYCLES if the byte is a command with data[7:2]==0 and data[1:0]≠0 (0x01, 0x02, 0x03);
  - otherwise SHORT_WAIT_CYCLES. Command 0x00 uses the short wait.
- ACK (host transfers only): ctrl_data_ack=1 while ctrl_data_req=1. On the edge that samples req=0, ack→0 and the state goes to IDLE.
- Requests during init (init_done=0) are ignored; req stays pending until IDLE.
- ctrl_data and ctrl_data_is_cmd changes after the latch edge have no effect.
- Req falling before ACK: the transfer completes in full; ack is high for exactly 1 cycle, then IDLE.
- A single down-counter, wide enough for the largest parameter, times all phases.

## Timing
- Let T be the edge on which a transfer is latched (host request in IDLE, or init byte load).
- lcd_e rises at edge T+SETUP_CYCLES.
- lcd_e falls at edge T+SETUP_CYCLES+PULSE_CYCLES.
- EXEC_WAIT begins at edge T+SETUP_CYCLES+PULSE_CYCLES+HOLD_CYCLES (H).
- ctrl_data_ack rises at edge H+W, where W is the selected wait.
- Host req→latch latency: 1 clock (req sampled high in IDLE at edge T).
- Minimum spacing between host transfers: ack fall + 1 clock (IDLE) before the next latch.
- init_done rises on the same edge that the final init EXEC_WAIT completes.
- Reset asserted mid-transfer or mid-init:
  - all outputs return to reset values asynchronously, including lcd_e=0 immediately;
  - on release, the full POWER_WAIT and init sequence restarts.

## Test plan
- Reset release with params 2/3/1/5/20/50: lcd_e stays 0 for 50 clocks, then four e-pulses with data 0x38, 0x0C, 0x01, 0x06, rs=0. Gaps are 5/5/20/5 cycles after hold. init_done=1 after the 4th wait; ack never rises.
- Data write 0x41, is_cmd=0, after init: rs=1, data=0x41 from T. e high for edges T+2..T+5. Ack rises at T+2+3+1+5. Ack falls one clock after req drops.
- Command 0x01 vs 0x80: ack rises 20 vs 5 wait cycles after the hold ends; rs=0 both.
- Req asserted during POWER_WAIT: no e pulse from the request until init_done=1, then exactly one transfer with the latched byte.
- Req dropped during PULSE: the transfer completes, ack is high for one cycle, then IDLE. A new req is accepted on the next clock.
- rst pulsed while lcd_e=1: lcd_e→0 without waiting for a clock edge, init_done→0, and the 50-clock power wait restarts.
